prt_vtb_vid2axis: RTL and testbench
===================================

// Module: prt_vtb_vid2axis
// PURPOSE
// Native-to-AXIS video converter: return path of the video toolbox, mirror of the AXIS-to-native FIFO.
// Captures native video (VS/HS/DE, RGB, P_PPC pixels per clock) and packs each active clock into one AXIS word.
// Marks start of frame and end of line, and buffers words in a FIFO to absorb AXIS back-pressure.
// Exposes overflow, line-count and pixel-count status to the toolbox controller.
// PARAMETERS
// P_PPC        2    pixels per clock
// P_BPC        8    bits per component
// P_AXIS_DAT   48   AXIS data width; must equal 3*P_BPC*P_PPC
// P_FIFO_DEPTH 64   FIFO depth in words; power of two, >=4
// PORTS
// CLK_IN           in   1               clock; single domain
// RST_IN           in   1               synchronous reset, active low
// CTL_RUN_IN       in   1               run enable
// VID_CKE_IN       in   1               video clock enable; native inputs are sampled only when 1
// VID_VS_IN        in   1               vsync, active high
// VID_HS_IN        in   1               hsync; pipelined only, no function
// VID_DE_IN        in   1               data enable
// VID_R/G/B_IN     in   P_BPC*P_PPC     components; pixel p occupies [p*P_BPC+:P_BPC]
// AXIS_SOF_OUT     out  1               start of frame (tuser)
// AXIS_EOL_OUT     out  1               end of line (tlast)
// AXIS_DAT_OUT     out  P_AXIS_DAT      data; pixel p = {B,G,R} at [p*3*P_BPC+:3*P_BPC], R in the LSBs
// AXIS_VLD_OUT     out  1               valid
// AXIS_RDY_IN      in   1               ready
// STA_OVF_OUT      out  1               sticky FIFO overflow
// STA_LIN_OUT      out  16              lines (EOL words) in the last complete frame
// STA_PIX_OUT      out  16              words in the last complete line
// BEHAVIOUR
// - Reset (RST_IN=0 at a clock edge) forces all outputs to 0, empties the FIFO and sets the FSM to IDLE.
// - FSM transitions (VS edge = VS 0->1 between consecutive CKE samples):
//   - IDLE: entered when CTL_RUN_IN=0, from any state, on the next clock. Flushes the FIFO and clears the capture register.
//   - IDLE->WAIT_VS: when CTL_RUN_IN=1. Clears STA_OVF/LIN/PIX and the counters.
//   - WAIT_VS->ACTIVE: on a VS edge. Sets the SOF-pending flag. DE is ignored while in WAIT_VS.
//   - ACTIVE->WAIT_VS: on overflow.
// - Capture in ACTIVE, on CKE cycles only: one-word lookahead register {SOF, DATA, valid}.
//   - DE=1 and register valid: push the register with EOL=0, then load the new word.
//   - DE=0 and register valid: push the register with EOL=1, then clear valid. A line end is therefore known one CKE sample late.
//   - DE=1 and register empty: load only.
//   - A loaded word takes SOF=1 if SOF-pending is set, then SOF-pending clears.
//   - A VS edge in ACTIVE sets SOF-pending again. A word already held in the register keeps its own SOF.
// - FIFO: P_FIFO_DEPTH x (P_AXIS_DAT+2), registered output.
//   - AXIS_VLD_OUT = FIFO not empty. Transfer on VLD&RDY.
//   - SOF/EOL/DAT stay stable while VLD=1 and RDY=0.
//   - Latency with CKE held at 1: DE sample at edge N -> pushed at N+1 -> AXIS_VLD high after edge N+2.
// - Full decision uses the registered word count. A push while full is dropped even if a read happens in the same cycle.
//   - A dropped push sets STA_OVF_OUT=1 (held until IDLE->WAIT_VS) and discards the register.
//   - Capture stops until the next VS edge. Words already queued still drain.
// - Simultaneous push and pop when the FIFO is not full: count unchanged.
// - Status counters are 16 bit and saturate at 0xFFFF.
//   - The word counter latches into STA_PIX_OUT on each pushed EOL, then resets.
//   - The EOL counter latches into STA_LIN_OUT on each VS edge in ACTIVE, then resets.
// - No CKE-gated stalls on the AXIS side: RDY/VLD are evaluated every clock.
// TESTING
// - Reset: RST_IN=0 for 2 clocks mid-stream -> VLD, SOF, EOL and STA_* are 0 on the next edge; FIFO empty.
// - 4x3 frame, P_PPC=2, CKE=1, RDY=1 -> 6 words; first word SOF=1; words 2, 4, 6 EOL=1; STA_PIX=2; STA_LIN=3 after the next VS.
// - Pixel packing: R=0x11/0x21, G=0x12/0x22, B=0x13/0x23 -> AXIS_DAT = 48'h232221_131211.
// - Back-pressure: RDY=0 for 64 words, then a 65th DE word -> STA_OVF=1, capture halts; RDY=1 drains 64 words unchanged; restart at the next VS with SOF=1.
// - CKE toggling 1/0 with a 3-word line -> exactly 3 words; EOL on word 3; no duplicates.
// - CTL_RUN_IN dropped mid-line -> VLD=0 within 2 clocks; re-run -> no output until a VS edge; STA_* cleared.

Source files
------------

// File: rtl/prt_vtb_vid2axis.sv
// Native video to AXIS converter: packs each active clock of VS/HS/DE video into one AXIS word
// through a one-word lookahead (to mark end of line) and a back-pressure FIFO with status counters.
module prt_vtb_vid2axis #(
    parameter int P_PPC        = 2,
    parameter int P_BPC        = 8,
    parameter int P_AXIS_DAT   = 48,
    parameter int P_FIFO_DEPTH = 64
) (
    input  logic                     CLK_IN,
    input  logic                     RST_IN,
    input  logic                     CTL_RUN_IN,
    input  logic                     VID_CKE_IN,
    input  logic                     VID_VS_IN,
    input  logic                     VID_HS_IN,
    input  logic                     VID_DE_IN,
    input  logic [P_BPC*P_PPC-1:0]   VID_R_IN,
    input  logic [P_BPC*P_PPC-1:0]   VID_G_IN,
    input  logic [P_BPC*P_PPC-1:0]   VID_B_IN,
    output logic                     AXIS_SOF_OUT,
    output logic                     AXIS_EOL_OUT,
    output logic [P_AXIS_DAT-1:0]    AXIS_DAT_OUT,
    output logic                     AXIS_VLD_OUT,
    input  logic                     AXIS_RDY_IN,
    output logic                     STA_OVF_OUT,
    output logic [15:0]              STA_LIN_OUT,
    output logic [15:0]              STA_PIX_OUT
);
    localparam int LP_AW = $clog2(P_FIFO_DEPTH);
    localparam int LP_W  = P_AXIS_DAT + 2;
    localparam int LP_PW = P_BPC * P_PPC;
    localparam logic [LP_AW:0] LP_FULL = (LP_AW+1)'(P_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [P_AXIS_DAT-1:0] pack_pix(input logic [LP_PW-1:0] r,
                                                       input logic [LP_PW-1:0] g,
                                                       input logic [LP_PW-1:0] b);
        logic [P_AXIS_DAT-1:0] d;
        d = '0;
        for (int p = 0; p < P_PPC; p++) begin
            d[p*3*P_BPC +: 3*P_BPC] = {b[p*P_BPC +: P_BPC], g[p*P_BPC +: P_BPC], r[p*P_BPC +: P_BPC]};
        end
        return d;
    endfunction

    state_t                state_q, state_d;
    logic                  vs_q;
    logic                  sof_pend_q, sof_pend_d;
    logic                  cap_vld_q, cap_vld_d;
    logic                  cap_sof_q, cap_sof_d;
    logic [P_AXIS_DAT-1:0] cap_dat_q, cap_dat_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           lin_q, lin_d, pix_q, pix_d;
    logic [15:0]           lin_cnt_q, lin_cnt_d, pix_cnt_q, pix_cnt_d;
    logic [LP_W-1:0]       mem_q [P_FIFO_DEPTH];
    logic [LP_AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LP_AW:0]        cnt_q;
    logic                  out_vld_q;
    logic [LP_W-1:0]       out_q;

    logic                  vs_edge_s, full_s, pop_s, push_req_s, push_eol_s, push_ok_s;
    logic [15:0]           lin_inc_s;
    logic [LP_AW-1:0]      rd_nxt_s;
    logic [LP_AW:0]        cnt_pop_s;
    logic                  hs_unused_s;

    // HSYNC carries no function in this direction.
    assign hs_unused_s = VID_HS_IN;

    assign vs_edge_s = VID_CKE_IN & VID_VS_IN & ~vs_q;
    assign full_s    = (cnt_q == LP_FULL);
    assign pop_s     = out_vld_q & AXIS_RDY_IN;
    assign rd_nxt_s  = pop_s ? rd_ptr_q + LP_AW'(1) : rd_ptr_q;
    assign cnt_pop_s = cnt_q - (LP_AW+1)'(pop_s);

    // Sequencing, lookahead capture and status counter next-state.
    always_comb begin
        state_d    = state_q;
        sof_pend_d = sof_pend_q;
        cap_vld_d  = cap_vld_q;
        cap_sof_d  = cap_sof_q;
        cap_dat_d  = cap_dat_q;
        ovf_d      = ovf_q;
        lin_d      = lin_q;
        pix_d      = pix_q;
        lin_cnt_d  = lin_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        push_req_s = 1'b0;
        push_eol_s = 1'b0;
        push_ok_s  = 1'b0;
        lin_inc_s  = lin_cnt_q;
        case (state_q)
            ST_IDLE: begin
                cap_vld_d = 1'b0;
                if (CTL_RUN_IN) begin
                    state_d    = ST_WAIT_VS;
                    ovf_d      = 1'b0;
                    lin_d      = 16'd0;
                    pix_d      = 16'd0;
                    lin_cnt_d  = 16'd0;
                    pix_cnt_d  = 16'd0;
                    sof_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (vs_edge_s) begin
                    state_d    = ST_ACTIVE;
                    sof_pend_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_ACTIVE: begin
                if (VID_CKE_IN) begin
                    push_req_s = cap_vld_q;
                    push_eol_s = ~VID_DE_IN;
                    push_ok_s  = cap_vld_q & ~full_s;
                    if (VID_DE_IN) begin
                        cap_vld_d  = 1'b1;
                        cap_sof_d  = sof_pend_q;
                        cap_dat_d  = pack_pix(VID_R_IN, VID_G_IN, VID_B_IN);
                        sof_pend_d = 1'b0;
                    end else begin
                        cap_vld_d = 1'b0;
                    end
                    // A new VS re-arms SOF for the next loaded word only.
                    if (vs_edge_s) begin
                        sof_pend_d = 1'b1;
                    end else begin
                        sof_pend_d = sof_pend_d;
                    end
                    if (push_req_s && full_s) begin
                        ovf_d     = 1'b1;
                        cap_vld_d = 1'b0;
                        state_d   = ST_WAIT_VS;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (push_ok_s && push_eol_s) begin
                        pix_d     = sat_inc(pix_cnt_q);
                        pix_cnt_d = 16'd0;
                        lin_inc_s = sat_inc(lin_cnt_q);
                    end else if (push_ok_s) begin
                        pix_cnt_d = sat_inc(pix_cnt_q);
                    end else begin
                        pix_cnt_d = pix_cnt_q;
                    end
                    lin_cnt_d = lin_inc_s;
                    if (vs_edge_s) begin
                        lin_d     = lin_inc_s;
                        lin_cnt_d = 16'd0;
                    end else begin
                        lin_d = lin_q;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!CTL_RUN_IN) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b0;
            sof_pend_q <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_sof_q  <= 1'b0;
            cap_dat_q  <= '0;
            ovf_q      <= 1'b0;
            lin_q      <= 16'd0;
            pix_q      <= 16'd0;
            lin_cnt_q  <= 16'd0;
            pix_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            vs_q       <= VID_CKE_IN ? VID_VS_IN : vs_q;
            sof_pend_q <= sof_pend_d;
            cap_vld_q  <= cap_vld_d;
            cap_sof_q  <= cap_sof_d;
            cap_dat_q  <= cap_dat_d;
            ovf_q      <= ovf_d;
            lin_q      <= lin_d;
            pix_q      <= pix_d;
            lin_cnt_q  <= lin_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // FIFO storage; a push while full never reaches memory.
    always_ff @(posedge CLK_IN) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= {cap_sof_q, push_eol_s, cap_dat_q};
        end
    end

    // FIFO pointers and registered head; the head reflects the queue after this cycle's pop.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN || state_q == ST_IDLE) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wr_ptr_q  <= push_ok_s ? wr_ptr_q + LP_AW'(1) : wr_ptr_q;
            rd_ptr_q  <= rd_nxt_s;
            cnt_q     <= cnt_pop_s + (LP_AW+1)'(push_ok_s);
            out_vld_q <= (cnt_pop_s != '0);
            out_q     <= (cnt_pop_s != '0) ? mem_q[rd_nxt_s] : '0;
        end
    end

    assign AXIS_SOF_OUT = out_q[LP_W-1];
    assign AXIS_EOL_OUT = out_q[LP_W-2];
    assign AXIS_DAT_OUT = out_q[P_AXIS_DAT-1:0];
    assign AXIS_VLD_OUT = out_vld_q;
    assign STA_OVF_OUT  = ovf_q;
    assign STA_LIN_OUT  = lin_q;
    assign STA_PIX_OUT  = pix_q;

endmodule

// File: tb/tb_prt_vtb_vid2axis.sv
// Self-checking bench for prt_vtb_vid2axis: random frames are described at frame/line/word level and
// the expected AXIS word stream is built from those descriptions, then compared with what the DUT emits.
module tb_prt_vtb_vid2axis;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        cke = 1'b0;
    logic        vs = 1'b0;
    logic        hs = 1'b0;
    logic        de = 1'b0;
    logic [15:0] r = 16'd0, g = 16'd0, b = 16'd0;
    logic        rdy = 1'b1;
    logic        sof, eol, vld, ovf;
    logic [47:0] dat;
    logic [15:0] lin, pix;

    int checks = 0;
    int failures = 0;
    logic [49:0] exp_q[$];
    logic [49:0] rx_q[$];

    always #5 clk = ~clk;

    prt_vtb_vid2axis #(.P_PPC(2), .P_BPC(8), .P_AXIS_DAT(48), .P_FIFO_DEPTH(64)) dut (
        .CLK_IN(clk), .RST_IN(rst_n), .CTL_RUN_IN(run), .VID_CKE_IN(cke),
        .VID_VS_IN(vs), .VID_HS_IN(hs), .VID_DE_IN(de),
        .VID_R_IN(r), .VID_G_IN(g), .VID_B_IN(b),
        .AXIS_SOF_OUT(sof), .AXIS_EOL_OUT(eol), .AXIS_DAT_OUT(dat),
        .AXIS_VLD_OUT(vld), .AXIS_RDY_IN(rdy),
        .STA_OVF_OUT(ovf), .STA_LIN_OUT(lin), .STA_PIX_OUT(pix)
    );

    always @(negedge clk) begin
        if (rst_n && vld && rdy) rx_q.push_back({sof, eol, dat});
    end

    function automatic logic [47:0] pack_pix(input logic [15:0] rr, input logic [15:0] gg, input logic [15:0] bb);
        logic [47:0] w;
        for (int p = 0; p < 2; p++) w[p*24 +: 24] = {bb[p*8 +: 8], gg[p*8 +: 8], rr[p*8 +: 8]};
        return w;
    endfunction

    task automatic tick(input logic c, input logic v, input logic d,
                        input logic [15:0] rr, input logic [15:0] gg, input logic [15:0] bb);
        @(posedge clk);
        #1;
        cke = c; vs = v; de = d; r = rr; g = gg; b = bb;
        hs = 1'($urandom_range(0, 1));
    endtask

    // One video sample; with tog a CKE=0 cycle carrying junk follows it.
    task automatic sample(input bit tog, input logic v, input logic d,
                          input logic [15:0] rr, input logic [15:0] gg, input logic [15:0] bb);
        tick(1'b1, v, d, rr, gg, bb);
        if (tog) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic blank(input bit tog, input int n);
        for (int i = 0; i < n; i++) sample(tog, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic frame_start(input bit tog);
        blank(tog, 2);
        sample(tog, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        blank(tog, 2);
    endtask

    task automatic send_frame(input int lines, input int wpl, input bit tog, input bit fixed,
                              input logic [15:0] fr, input logic [15:0] fg, input logic [15:0] fb);
        logic [15:0] rr, gg, bb;
        frame_start(tog);
        for (int l = 0; l < lines; l++) begin
            for (int w = 0; w < wpl; w++) begin
                rr = fixed ? fr : 16'($urandom);
                gg = fixed ? fg : 16'($urandom);
                bb = fixed ? fb : 16'($urandom);
                exp_q.push_back({(l == 0 && w == 0), (w == wpl - 1), pack_pix(rr, gg, bb)});
                sample(tog, 1'b0, 1'b1, rr, gg, bb);
            end
            blank(tog, 2);
        end
        blank(tog, 1);
        sample(tog, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        blank(tog, 3);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (rx_q.size() >= exp_q.size() && !vld) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", vld); end
        checks++; if ({sof, eol} !== 2'b00) begin failures++; $display("FAIL reset_sof_eol got=%b exp=00", {sof, eol}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if ({lin, pix} !== 32'd0) begin failures++; $display("FAIL reset_sta got=%h/%h exp=0/0", lin, pix); end
    endtask

    task automatic test_frame();
        run = 1'b1;
        blank(1'b0, 2);
        send_frame(3, 2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        drain();
        checks++; if (rx_q.size() !== 6) begin failures++; $display("FAIL frame_words got=%0d exp=6", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (pix !== 16'd2) begin failures++; $display("FAIL frame_sta_pix got=%0d exp=2", pix); end
        checks++; if (lin !== 16'd3) begin failures++; $display("FAIL frame_sta_lin got=%0d exp=3", lin); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_packing();
        logic [47:0] want;
        want = 48'h232221_131211;
        send_frame(1, 1, 1'b0, 1'b1, 16'h2111, 16'h2212, 16'h2313);
        drain();
        checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL pack_words got=%0d exp=1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++;
            if (rx_q[0] !== {2'b11, want}) begin failures++; $display("FAIL pack_data got=%h exp=%h", rx_q[0], {2'b11, want}); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_cke();
        send_frame(1, 3, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        drain();
        checks++; if (rx_q.size() !== 3) begin failures++; $display("FAIL cke_words got=%0d exp=3", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL cke_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if ({lin, pix} !== {16'd1, 16'd3}) begin failures++; $display("FAIL cke_sta got=%0d/%0d exp=1/3", lin, pix); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int nl, nw;
        bit tog, done;
        for (int it = 0; it < 3; it++) begin
            nl = $urandom_range(2, 4);
            nw = $urandom_range(1, 5);
            tog = 1'($urandom_range(0, 1));
            done = 1'b0;
            fork
                begin send_frame(nl, nw, tog, 1'b0, 16'd0, 16'd0, 16'd0); done = 1'b1; end
                begin while (!done) begin @(posedge clk); #2; rdy = 1'($urandom_range(0, 1)); end end
            join
            rdy = 1'b1;
            drain();
            checks++; if (rx_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_words got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
            end
            checks++; if ({lin, pix} !== {16'(nl), 16'(nw)}) begin failures++; $display("FAIL b2b_sta got=%0d/%0d exp=%0d/%0d", lin, pix, nl, nw); end
            rx_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rr, gg, bb;
        rdy = 1'b0;
        frame_start(1'b0);
        for (int w = 0; w < 65; w++) begin
            rr = 16'($urandom); gg = 16'($urandom); bb = 16'($urandom);
            if (w < 64) exp_q.push_back({(w == 0), 1'b0, pack_pix(rr, gg, bb)});
            sample(1'b0, 1'b0, 1'b1, rr, gg, bb);
        end
        blank(1'b0, 1);
        for (int w = 0; w < 4; w++) sample(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
        blank(1'b0, 2);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vld, sof, eol, dat} !== {1'b1, exp_q[0]}) begin
                failures++; $display("FAIL bp_head_stable got=%h exp=%h", {vld, sof, eol, dat}, {1'b1, exp_q[0]});
            end
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        drain();
        checks++; if (rx_q.size() !== 64) begin failures++; $display("FAIL bp_words got=%0d exp=64", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
        send_frame(1, 2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        drain();
        checks++; if (rx_q.size() !== 2) begin failures++; $display("FAIL bp_restart_words got=%0d exp=2", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_restart_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_run_drop();
        rdy = 1'b0;
        frame_start(1'b0);
        for (int w = 0; w < 4; w++) sample(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
        checks++; if (vld !== 1'b1) begin failures++; $display("FAIL drop_pre_vld got=%b exp=1", vld); end
        run = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL drop_vld got=%b exp=0", vld); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL drop_ovf_held got=%b exp=1", ovf); end
        rx_q.delete();
        rdy = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 10; i++) sample(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
        checks++; if (rx_q.size() !== 0 || vld !== 1'b0) begin failures++; $display("FAIL rerun_no_output got=%0d/%b exp=0/0", rx_q.size(), vld); end
        checks++; if ({ovf, lin, pix} !== 33'd0) begin failures++; $display("FAIL rerun_sta_clear got=%b/%0d/%0d exp=0/0/0", ovf, lin, pix); end
        send_frame(1, 2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        drain();
        checks++; if (rx_q.size() !== 2) begin failures++; $display("FAIL rerun_words got=%0d exp=2", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rerun_word%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        rdy = 1'b0;
        frame_start(1'b0);
        for (int w = 0; w < 5; w++) sample(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if ({vld, sof, eol} !== 3'b000) begin failures++; $display("FAIL mid_reset_out got=%b exp=000", {vld, sof, eol}); end
        checks++; if ({ovf, lin, pix} !== 33'd0) begin failures++; $display("FAIL mid_reset_sta got=%b/%0d/%0d exp=0/0/0", ovf, lin, pix); end
        rst_n = 1'b1;
        rdy = 1'b1;
        rx_q.delete();
        blank(1'b0, 10);
        checks++; if (rx_q.size() !== 0 || vld !== 1'b0) begin failures++; $display("FAIL mid_reset_empty got=%0d/%b exp=0/0", rx_q.size(), vld); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_packing();
        test_cke();
        test_back_to_back();
        test_backpressure();
        test_run_drop();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
